uart_rx_with_buffer: RTL and testbench

// Receive side of the board UART link: 115200 baud, 8 data bits LSB first, 1 stop bit, no parity.

---
 rtl/uart_rx_with_buffer_if.sv | 25 ++
 rtl/uart_rx_with_buffer.sv | 195 +++++++++++++++++++
 tb/tb_uart_rx_with_buffer.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_with_buffer_if.sv
// Byte stream from the UART receive FIFO head to its consumer.
// Latency: none; this is a plain bundle of wires.
// Backpressure: consumer holds out_ready low to keep the head byte in place.
//
// Signals:
//   out_data   head byte, meaningful only while out_valid=1
//   out_valid  FIFO holds at least one byte
//   out_ready  consumer takes the head byte when out_valid && out_ready
interface uart_rx_with_buffer_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/uart_rx_with_buffer.sv
// UART receiver (8N1, LSB first) feeding a first-word-fall-through byte FIFO.
// Latency: byte visible on dout the cycle after its stop bit is sampled (rx has 2-cycle sync delay).
// Backpressure: FIFO absorbs up to 2**FIFO_AW bytes; a byte completing into a full FIFO is dropped and flagged.
//
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   rx            serial input, idles high, asynchronous to clk
//   dout          head-of-FIFO stream (out_data / out_valid / out_ready)
//   fifo_count    bytes held, 0..2**FIFO_AW
//   frame_error   one-cycle pulse when a stop bit is sampled low
//   overflow      sticky, set when a completed byte is dropped
//   clear_errors  synchronous clear of overflow
module uart_rx_with_buffer #(
    parameter int CLK_PER_BIT = 868,
    parameter int FIFO_AW     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    uart_rx_with_buffer_if.master dout,
    output logic [FIFO_AW:0]     fifo_count,
    output logic                 frame_error,
    output logic                 overflow,
    input  logic                 clear_errors
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam int CW    = FIFO_AW + 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]    CNT_MAX  = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    // ---------------------------------------------------------------
    // Input synchroniser; flops reset to the idle (high) line level so
    // reset never looks like a start bit.
    // ---------------------------------------------------------------
    logic rx_meta;
    logic rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // ---------------------------------------------------------------
    // Receive FSM. The counter counts down and a sample is taken in the
    // cycle it reads zero; the start bit is loaded with half a bit so
    // every later sample lands mid-bit.
    // ---------------------------------------------------------------
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             tick;
    logic             push_vld;

    assign tick     = (cnt == '0);
    assign push_vld = (state == S_STOP) && tick && rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            frame_error <= 1'b0;
        end else begin
            frame_error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state <= S_START;
                        cnt   <= CNT_HALF;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (!rx_s) begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                            cnt     <= CNT_FULL;
                        end else begin
                            // Line went back high before mid start bit: noise.
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        shift[bit_idx] <= rx_s;
                        cnt            <= CNT_FULL;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        if (rx_s) begin
                            state <= S_IDLE;
                        end else begin
                            frame_error <= 1'b1;
                            state       <= S_BREAK;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_BREAK: begin
                    // A held-low line must return high before a new start bit counts.
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // FWFT FIFO. A push into a full FIFO is still taken when the head is
    // popped in the same cycle: the write lands in the slot being freed.
    // ---------------------------------------------------------------
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [CW-1:0]      count;
    logic               pop;
    logic               push_ok;
    logic               drop;

    assign pop     = dout.out_valid && dout.out_ready;
    assign push_ok = push_vld && ((count != CNT_MAX) || pop);
    assign drop    = push_vld && !push_ok;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= shift;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // A fresh drop outranks a clear in the same cycle.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_errors) begin
                overflow <= 1'b0;
            end
        end
    end

    assign fifo_count     = count;
    assign dout.out_valid = (count != '0);
    // Memory is not reset, so the head is masked to zero while empty.
    assign dout.out_data  = dout.out_valid ? mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_uart_rx_with_buffer.sv
// Directed bench for uart_rx_with_buffer, run with a short bit period.
// Latency: checks the byte appears exactly one cycle after the stop-bit sample.
// Backpressure: exercises full FIFO, drop, and push-with-pop at full.
module tb_uart_rx_with_buffer;

    localparam int CPB = 32;
    localparam int AW  = 4;
    // Negedges after the stop bit is driven until the cycle following its sample:
    // 2 sync flops + 1 IDLE->START + CPB/2 start countdown.
    localparam int SO  = 3 + CPB / 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx;
    logic          clear_errors;
    logic [AW:0]   fifo_count;
    logic          frame_error;
    logic          overflow;

    uart_rx_with_buffer_if bus ();

    uart_rx_with_buffer #(
        .CLK_PER_BIT (CPB),
        .FIFO_AW     (AW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .dout         (bus),
        .fifo_count   (fifo_count),
        .frame_error  (frame_error),
        .overflow     (overflow),
        .clear_errors (clear_errors)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int fe_cnt   = 0;

    always @(negedge clk) begin
        if (frame_error === 1'b1) fe_cnt++;
    end

    // Values captured around the stop-bit sample of the most recent frame.
    logic        pre_valid;
    logic        post_valid;
    logic [7:0]  post_data;
    logic [7:0]  head_at_stop;
    logic [AW:0] post_count;
    logic        post_ovf;
    logic        fe_pre;
    logic        fe_at;
    logic        fe_after;

    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input logic pop_at_stop, input logic clr_at_stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        for (int j = 1; j <= CPB; j++) begin
            @(negedge clk);
            if (j == SO - 1) begin
                pre_valid    = bus.out_valid;
                head_at_stop = bus.out_data;
                fe_pre       = frame_error;
                if (pop_at_stop) bus.out_ready = 1'b1;
                if (clr_at_stop) clear_errors = 1'b1;
            end
            if (j == SO) begin
                post_valid    = bus.out_valid;
                post_data     = bus.out_data;
                post_count    = fifo_count;
                post_ovf      = overflow;
                fe_at         = frame_error;
                bus.out_ready = 1'b0;
                clear_errors  = 1'b0;
            end
            if (j == SO + 1) fe_after = frame_error;
        end
    endtask

    task automatic pop_byte(output logic [7:0] d);
        @(negedge clk);
        d = bus.out_data;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rx = 1'b1;
        clear_errors = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        if (bus.out_valid !== 1'b0) begin $display("FAIL reset_valid got %b want 0", bus.out_valid); n_fail++; end
        n_checks++;
        if (bus.out_data !== 8'h00) begin $display("FAIL reset_data got %h want 00", bus.out_data); n_fail++; end
        n_checks++;
        if (fifo_count !== 5'd0) begin $display("FAIL reset_count got %0d want 0", fifo_count); n_fail++; end
        n_checks++;
        if (frame_error !== 1'b0) begin $display("FAIL reset_fe got %b want 0", frame_error); n_fail++; end
        n_checks++;
        if (overflow !== 1'b0) begin $display("FAIL reset_ovf got %b want 0", overflow); n_fail++; end
        n_checks++;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_single_byte;
        logic [7:0] d;
        send_frame(8'h55, 1'b1, 1'b0, 1'b0);
        if (pre_valid !== 1'b0) begin $display("FAIL t1_pre_valid got %b want 0", pre_valid); n_fail++; end
        n_checks++;
        if (post_valid !== 1'b1) begin $display("FAIL t1_valid got %b want 1", post_valid); n_fail++; end
        n_checks++;
        if (post_data !== 8'h55) begin $display("FAIL t1_data got %h want 55", post_data); n_fail++; end
        n_checks++;
        if (post_count !== 5'd1) begin $display("FAIL t1_count got %0d want 1", post_count); n_fail++; end
        n_checks++;
        pop_byte(d);
        if (d !== 8'h55) begin $display("FAIL t1_pop got %h want 55", d); n_fail++; end
        n_checks++;
        if (fifo_count !== 5'd0) begin $display("FAIL t1_count_after got %0d want 0", fifo_count); n_fail++; end
        n_checks++;
        if (bus.out_valid !== 1'b0) begin $display("FAIL t1_valid_after got %b want 0", bus.out_valid); n_fail++; end
        n_checks++;
    endtask

    task automatic test_glitch;
        int fe0;
        logic [7:0] d;
        fe0 = fe_cnt;
        @(negedge clk);
        rx = 1'b0;
        repeat (7) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        if (bus.out_valid !== 1'b0) begin $display("FAIL t2_valid got %b want 0", bus.out_valid); n_fail++; end
        n_checks++;
        if (fe_cnt !== fe0) begin $display("FAIL t2_fe_pulses got %0d want %0d", fe_cnt, fe0); n_fail++; end
        n_checks++;
        // A clean frame right after shows the FSM went back to IDLE.
        send_frame(8'hE7, 1'b1, 1'b0, 1'b0);
        if (post_data !== 8'hE7) begin $display("FAIL t2_next_data got %h want e7", post_data); n_fail++; end
        n_checks++;
        pop_byte(d);
    endtask

    task automatic test_frame_error;
        int fe0;
        logic [7:0] d;
        fe0 = fe_cnt;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        if (fe_pre !== 1'b0) begin $display("FAIL t3_fe_pre got %b want 0", fe_pre); n_fail++; end
        n_checks++;
        if (fe_at !== 1'b1) begin $display("FAIL t3_fe_at got %b want 1", fe_at); n_fail++; end
        n_checks++;
        if (fe_after !== 1'b0) begin $display("FAIL t3_fe_after got %b want 0", fe_after); n_fail++; end
        n_checks++;
        if (post_count !== 5'd0) begin $display("FAIL t3_count got %0d want 0", post_count); n_fail++; end
        n_checks++;
        repeat (5 * CPB) @(negedge clk);
        if (fifo_count !== 5'd0) begin $display("FAIL t3_break_count got %0d want 0", fifo_count); n_fail++; end
        n_checks++;
        if (fe_cnt !== fe0 + 1) begin $display("FAIL t3_fe_pulses got %0d want %0d", fe_cnt, fe0 + 1); n_fail++; end
        n_checks++;
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        if (post_data !== 8'h3C) begin $display("FAIL t3_next_data got %h want 3c", post_data); n_fail++; end
        n_checks++;
        if (post_count !== 5'd1) begin $display("FAIL t3_next_count got %0d want 1", post_count); n_fail++; end
        n_checks++;
        pop_byte(d);
    endtask

    task automatic test_overflow;
        logic [7:0] d;
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 1'b1, 1'b0, 1'b0);
            if (i == 15) begin
                if (post_ovf !== 1'b0) begin $display("FAIL t4_ovf_at16 got %b want 0", post_ovf); n_fail++; end
                n_checks++;
            end
        end
        if (post_count !== 5'd16) begin $display("FAIL t4_count got %0d want 16", post_count); n_fail++; end
        n_checks++;
        if (post_ovf !== 1'b1) begin $display("FAIL t4_ovf got %b want 1", post_ovf); n_fail++; end
        n_checks++;
        for (int i = 0; i < 16; i++) begin
            pop_byte(d);
            if (d !== 8'(i)) begin $display("FAIL t4_drain[%0d] got %h want %h", i, d, 8'(i)); n_fail++; end
            n_checks++;
        end
        if (bus.out_valid !== 1'b0) begin $display("FAIL t4_empty got valid=%b want 0", bus.out_valid); n_fail++; end
        n_checks++;
        if (overflow !== 1'b1) begin $display("FAIL t4_sticky got %b want 1", overflow); n_fail++; end
        n_checks++;
        @(negedge clk);
        clear_errors = 1'b1;
        @(negedge clk);
        clear_errors = 1'b0;
        if (overflow !== 1'b0) begin $display("FAIL t4_clear got %b want 0", overflow); n_fail++; end
        n_checks++;
    endtask

    task automatic test_full_push_pop;
        logic [7:0] d;
        logic [7:0] exp;
        for (int i = 0; i < 16; i++) send_frame(8'h40 + 8'(i), 1'b1, 1'b0, 1'b0);
        send_frame(8'h99, 1'b1, 1'b1, 1'b0);
        if (head_at_stop !== 8'h40) begin $display("FAIL t5_popped got %h want 40", head_at_stop); n_fail++; end
        n_checks++;
        if (post_count !== 5'd16) begin $display("FAIL t5_count got %0d want 16", post_count); n_fail++; end
        n_checks++;
        if (post_ovf !== 1'b0) begin $display("FAIL t5_ovf got %b want 0", post_ovf); n_fail++; end
        n_checks++;
        // Drop and clear in the same cycle: the drop wins.
        send_frame(8'h77, 1'b1, 1'b0, 1'b1);
        if (post_ovf !== 1'b1) begin $display("FAIL t5_clr_vs_drop got %b want 1", post_ovf); n_fail++; end
        n_checks++;
        for (int i = 0; i < 16; i++) begin
            exp = (i == 15) ? 8'h99 : 8'h41 + 8'(i);
            pop_byte(d);
            if (d !== exp) begin $display("FAIL t5_drain[%0d] got %h want %h", i, d, exp); n_fail++; end
            n_checks++;
        end
        @(negedge clk);
        clear_errors = 1'b1;
        @(negedge clk);
        clear_errors = 1'b0;
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] d;
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0);
        send_frame(8'h33, 1'b1, 1'b0, 1'b0);
        if (fifo_count !== 5'd3) begin $display("FAIL t6_pre_count got %0d want 3", fifo_count); n_fail++; end
        n_checks++;
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = i[0];
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b0;
        repeat (CPB - 4) @(negedge clk);
        rst_n = 1'b0;
        rx = 1'b1;
        #1;
        if (fifo_count !== 5'd0) begin $display("FAIL t6_count got %0d want 0", fifo_count); n_fail++; end
        n_checks++;
        if (bus.out_valid !== 1'b0) begin $display("FAIL t6_valid got %b want 0", bus.out_valid); n_fail++; end
        n_checks++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (CPB) @(negedge clk);
        if (fifo_count !== 5'd0) begin $display("FAIL t6_no_partial got %0d want 0", fifo_count); n_fail++; end
        n_checks++;
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
        if (post_data !== 8'hC3) begin $display("FAIL t6_data got %h want c3", post_data); n_fail++; end
        n_checks++;
        if (post_count !== 5'd1) begin $display("FAIL t6_count_after got %0d want 1", post_count); n_fail++; end
        n_checks++;
        pop_byte(d);
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_glitch();
        test_frame_error();
        test_overflow();
        test_full_push_pop();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
